// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - debounced active-low pushbutton with press/release/long-press pulses
// Optional long-press detection is built only when BTN_LONG_PRESS_EN is defined.
module button_debounce #(
  parameter int DEBOUNCE_COUNT = 1000000,
  parameter int LONG_COUNT     = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic led_toggle
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  localparam logic [31:0] DEB_LAST = 32'(DEBOUNCE_COUNT - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        sync1_q, sync2_q;
  logic        btn_level_q, btn_level_d;
  logic        press_pulse_q, press_pulse_d;
  logic        release_pulse_q, release_pulse_d;
  logic        led_toggle_q, led_toggle_d;
  logic        press_accept;
  logic        pressed;

  assign pressed = ~sync2_q;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    btn_level_d     = btn_level_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    led_toggle_d    = led_toggle_q;
    press_accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_d = IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d       = PRESSED;
          btn_level_d   = 1'b1;
          press_pulse_d = 1'b1;
          led_toggle_d  = ~led_toggle_q;
          press_accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      PRESSED: begin
        if (!pressed) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        // A return to pressed is a release glitch: level and long count are kept.
        if (pressed) begin
          state_d = PRESSED;
        end else if (cnt_q == DEB_LAST) begin
          state_d         = IDLE;
          btn_level_d     = 1'b0;
          release_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q         <= 1'b1;
      sync2_q         <= 1'b1;
      state_q         <= IDLE;
      cnt_q           <= '0;
      btn_level_q     <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      led_toggle_q    <= 1'b0;
    end else begin
      sync1_q         <= btn_n;
      sync2_q         <= sync1_q;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      btn_level_q     <= btn_level_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      led_toggle_q    <= led_toggle_d;
    end
  end

`ifdef BTN_LONG_PRESS_EN
  localparam logic [31:0] LONG_LAST = 32'(LONG_COUNT - 1);

  logic [31:0] lcnt_q, lcnt_d;
  logic        long_done_q, long_done_d;
  logic        long_pulse_q, long_pulse_d;

  always_comb begin
    lcnt_d       = lcnt_q;
    long_done_d  = long_done_q;
    long_pulse_d = 1'b0;
    if (press_accept) begin
      lcnt_d      = '0;
      long_done_d = 1'b0;
    end else if (btn_level_q) begin
      // Saturate at the last count; long_done limits the pulse to once per press.
      if (lcnt_q == LONG_LAST) begin
        if (!long_done_q) begin
          long_pulse_d = 1'b1;
          long_done_d  = 1'b1;
        end
      end else begin
        lcnt_d = lcnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lcnt_q       <= '0;
      long_done_q  <= 1'b0;
      long_pulse_q <= 1'b0;
    end else begin
      lcnt_q       <= lcnt_d;
      long_done_q  <= long_done_d;
      long_pulse_q <= long_pulse_d;
    end
  end

  assign long_pulse = long_pulse_q;
`else
  logic unused_long_cfg;
  assign unused_long_cfg = press_accept ^ (LONG_COUNT == 0);
  assign long_pulse      = 1'b0;
`endif

  assign btn_level     = btn_level_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign led_toggle    = led_toggle_q;

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - randomized and directed check of button_debounce against a run-length model
module tb_button_debounce;

  localparam int D = 4;
  localparam int L = 10;

  logic clk = 1'b0;
  logic rst;
  logic btn_n;
  logic btn_level, press_pulse, release_pulse, long_pulse, led_toggle;

  button_debounce #(.DEBOUNCE_COUNT(D), .LONG_COUNT(L)) dut (
    .clk(clk), .rst(rst), .btn_n(btn_n),
    .btn_level(btn_level), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .led_toggle(led_toggle)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_press = -1, last_rel = -1, last_long = -1;
  int n_press = 0, n_rel = 0, n_long = 0;

  // Reference model: the filter sees the raw input two edges late and accepts
  // a new level after D+1 consecutive samples that disagree with the current one.
  logic m_h1, m_h2;
  logic m_level, m_press, m_rel, m_long, m_led, m_done;
  int   m_run, m_k;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge(input logic b, input logic r);
    logic s, old_level;
    m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
    if (r) begin
      m_h1 = 1'b1; m_h2 = 1'b1; m_level = 1'b0; m_led = 1'b0;
      m_run = 0; m_k = 0; m_done = 1'b0;
    end else begin
      s = ~m_h2;
      m_h2 = m_h1;
      m_h1 = b;
      old_level = m_level;
      m_run = (s != m_level) ? m_run + 1 : 0;
      if (m_run == D + 1) begin
        m_level = s;
        m_run = 0;
        if (s) begin
          m_press = 1'b1; m_led = ~m_led; m_k = 0; m_done = 1'b0;
        end else begin
          m_rel = 1'b1;
        end
      end
      if (old_level && !m_done) begin
        m_k++;
        if (m_k == L) begin
          m_long = 1'b1; m_done = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input logic b, input logic r);
    logic exp_long;
    btn_n = b;
    rst = r;
    @(posedge clk);
    model_edge(b, r);
    cyc++;
    #1;
`ifdef BTN_LONG_PRESS_EN
    exp_long = m_long;
`else
    exp_long = 1'b0;
`endif
    check("btn_level", btn_level, m_level);
    check("press_pulse", press_pulse, m_press);
    check("release_pulse", release_pulse, m_rel);
    check("long_pulse", long_pulse, exp_long);
    check("led_toggle", led_toggle, m_led);
    if (press_pulse) begin last_press = cyc; n_press++; end
    if (release_pulse) begin last_rel = cyc; n_rel++; end
    if (long_pulse) begin last_long = cyc; n_long++; end
  endtask

  task automatic run(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b0);
  endtask

  initial begin
    int t0, p0, r0, l0, len;
    logic b;
    btn_n = 1'b1;
    rst = 1'b1;
    m_h1 = 1'b1; m_h2 = 1'b1; m_level = 1'b0; m_led = 1'b0;
    m_run = 0; m_k = 0; m_done = 1'b0;
    m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    check("reset_level", btn_level, 0);
    check("reset_led", led_toggle, 0);
    run(1'b1, 4);

    // Clean press
    t0 = cyc + 1; last_press = -1;
    run(1'b0, 20);
    check("press_latency", 32'(last_press - t0), 6);
    check("press_led", led_toggle, 1);
    check("press_level", btn_level, 1);

    // Release with a one-cycle glitch
    p0 = n_press; r0 = n_rel; last_rel = -1;
    run(1'b1, 2);
    run(1'b0, 1);
    t0 = cyc + 1;
    run(1'b1, 12);
    check("release_latency", 32'(last_rel - t0), 6);
    check("release_count", 32'(n_rel - r0), 1);
    check("glitch_no_press", 32'(n_press - p0), 0);
    check("release_level", btn_level, 0);

    // Bounce shorter than the debounce window
    p0 = n_press; r0 = n_rel;
    for (int i = 0; i < 4; i++) begin
      run(1'b0, 3);
      run(1'b1, 1);
    end
    run(1'b1, 8);
    check("bounce_press", 32'(n_press - p0), 0);
    check("bounce_release", 32'(n_rel - r0), 0);
    check("bounce_level", btn_level, 0);

    // Long press
    l0 = n_long; last_press = -1; last_long = -1;
    run(1'b0, 30);
`ifdef BTN_LONG_PRESS_EN
    check("long_count", 32'(n_long - l0), 1);
    check("long_latency", 32'(last_long - last_press), L);
`else
    check("long_count", 32'(n_long - l0), 0);
`endif
    run(1'b1, 10);
    check("long_release_level", btn_level, 0);

    // Reset mid-press, button held through reset release
    run(1'b0, 8);
    check("pre_reset_level", btn_level, 1);
    r0 = n_rel;
    step(1'b0, 1'b1);
    check("rst_level", btn_level, 0);
    check("rst_led", led_toggle, 0);
    check("rst_no_release", 32'(n_rel - r0), 0);
    t0 = cyc + 1; last_press = -1;
    run(1'b0, 10);
    check("rst_press_latency", 32'(last_press - t0), 6);
    run(1'b1, 10);

    // Randomized runs with occasional reset
    while (cyc < 4000) begin
      b = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 25) : $urandom_range(1, 8);
      for (int i = 0; i < len; i++) step(b, ($urandom_range(0, 299) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
# button_debounce

Debounced pushbutton reader that pairs with the LED blinker in the board-level I/O path: where the blinker drives a board output, this block samples a raw, bouncing, asynchronous board input. It synchronizes the active-low input, filters bounce with a stability counter and a four-state FSM, and produces a clean level plus single-cycle press, release and optional long-press pulses. A press-toggled LED output lets a button directly drive an LED for bring-up.

## Interface
- DEBOUNCE_COUNT, 1000000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz); must be ≥1.
- LONG_COUNT, 50000000: cycles of accepted-pressed level before long_pulse fires (1 s at 50 MHz); must be ≥1.
- clk  input  1  single clock for all logic.
- rst  input  1  synchronous, active-high reset.
- btn_n  input  1  raw button, active-low (0 = pressed), asynchronous to clk.
- btn_level  output  1  debounced level, 1 = pressed.
- press_pulse  output  1  one-cycle pulse on accepted press.
- release_pulse  output  1  one-cycle pulse on accepted release.
- long_pulse  output  1  one-cycle pulse when a press has been held LONG_COUNT cycles.
- led_toggle  output  1  toggles on every press_pulse.

## Operation
- Synchronizer: two flops, sync1 then sync2; both reset to 1 (released); FSM uses pressed = ~sync2.
- Debounce counter cnt: 32-bit.
- FSM states:
  - IDLE: if pressed, go to PRESS_WAIT with cnt=0.
  - PRESS_WAIT: if not pressed, go to IDLE (bounce rejected, no pulse). If cnt==DEBOUNCE_COUNT-1, go to PRESSED, set btn_level=1, pulse press_pulse, flip led_toggle, clear the long counter. Otherwise cnt+1.
  - PRESSED: if not pressed, go to RELEASE_WAIT with cnt=0.
  - RELEASE_WAIT: if pressed, return to PRESSED; btn_level stays 1, no pulses, long counter not cleared. If cnt==DEBOUNCE_COUNT-1, go to IDLE, set btn_level=0, pulse release_pulse. Otherwise cnt+1.
- Long counter lcnt: 32-bit.
  - Increments every cycle btn_level==1, including during RELEASE_WAIT.
  - When lcnt==LONG_COUNT-1, long_pulse fires once and lcnt saturates. At most one long_pulse per accepted press.
- All outputs are registered.

## Timing
- Reset values:
  - btn_level, press_pulse, release_pulse, long_pulse, led_toggle = 0.
  - State = IDLE, cnt = 0, lcnt = 0, sync1 = sync2 = 1.
- Press latency: with btn_n held low from the first rising edge that samples 0 (edge 0), press_pulse and btn_level=1 appear after edge DEBOUNCE_COUNT+2.
- Release latency: same, DEBOUNCE_COUNT+2 edges after btn_n is first sampled high.
- long_pulse is high for the cycle after the LONG_COUNTth rising edge with btn_level=1.
- Pulse width: press_pulse, release_pulse and long_pulse are each exactly one cycle. press_pulse and release_pulse are never high together.
- Bounce shorter than DEBOUNCE_COUNT stable cycles produces no pulse and no btn_level change.
- Reset asserted mid-debounce or mid-press: on the next edge, all state returns to reset values, with no release_pulse.
- Button held through reset release: treated as a new press; press_pulse arrives DEBOUNCE_COUNT+2 edges after rst deasserts.
- Counters never wrap:
  - cnt is cleared on each entry to a WAIT state and stops at DEBOUNCE_COUNT-1.
  - lcnt saturates at LONG_COUNT-1.

## Configuration
- Macro BTN_LONG_PRESS_EN.
  - Defined: lcnt and long_pulse behave as above.
  - Undefined: lcnt is not built, LONG_COUNT is ignored, and long_pulse is tied to 0. All other behaviour and timing are unchanged.

## Test plan
Bench parameters: DEBOUNCE_COUNT=4, LONG_COUNT=10, BTN_LONG_PRESS_EN defined.
- Clean press: btn_n 1→0 held 20 cycles → press_pulse one cycle, 6 edges after the first low sample; btn_level=1; led_toggle 0→1.
- Bounce: btn_n low 3 cycles, high 1 cycle, repeated 4 times, then high → no pulses; btn_level stays 0.
- Release with glitch: from pressed, btn_n high 2 cycles, low 1 cycle, then high steady → a single release_pulse 6 edges after the last high transition is first sampled; btn_level=0; no second press_pulse.
- Long press: btn_n low 30 cycles → exactly one long_pulse, 10 edges after btn_level rises; none after that.
- Reset mid-press: assert rst while btn_level=1 → next cycle all outputs 0; keep btn_n low and deassert rst → press_pulse 6 edges later.
- Macro undefined: rerun the long-press scenario → long_pulse stays 0; press and release timing identical.
